// File: rtl/dac_com.sv
// dac_com: serialises 12-bit samples into 16-bit DAC frames {CTRL, sample}.
// Frame = 1 LOAD cycle, 16 bits of 2*CLK_DIV cycles, and a 2*CLK_DIV-cycle END
// gap. Sample storage is a single holding register by default. Defining the
// macro DAC_FIFO_EN replaces it with a 4-entry circular FIFO.
module dac_com #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [3:0]  CTRL    = 4'b0011
) (
  input  logic        osc_clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [11:0] wr_data,
  output logic        full,
  output logic        dac_clk,
  output logic        dac_cs_n,
  output logic        dac_din,
  output logic        busy,
  output logic        word_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_END} state_t;

  localparam logic [8:0] LP_HALF = 9'(CLK_DIV);
  localparam logic [8:0] LP_LAST = 9'(2 * CLK_DIV - 1);

  state_t      r_state;
  logic [8:0]  r_phase;
  logic [3:0]  r_bit;
  logic [15:0] r_shreg;
  logic        r_dac_clk;
  logic        r_cs_n;
  logic        r_word_done;
  logic [1:0]  r_rst_sync;

  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_store_full;
  logic [11:0] w_head;

  // Two-stage release synchroniser; pushes are refused until it has filled
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  // The oldest sample leaves storage at the end of the LOAD cycle, so a slot
  // is already free for a push arriving in that same cycle.
  assign w_pop  = (r_state == S_LOAD);
  assign full   = w_store_full && !w_pop;
  assign w_push = wr_en && !full && r_rst_sync[1];

`ifdef DAC_FIFO_EN
  logic [11:0] r_mem [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;

  // Sample array write; contents need no reset because r_count gates reads
  always_ff @(posedge osc_clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2 bits
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign w_empty      = (r_count == 3'd0);
  assign w_store_full = (r_count == 3'd4);
`else
  logic [11:0] r_hold;
  logic        r_valid;

  // Single holding register; a push in the LOAD cycle refills it
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold  <= 12'd0;
      r_valid <= 1'b0;
    end else if (w_push) begin
      r_hold  <= wr_data;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign w_head       = r_hold;
  assign w_empty      = !r_valid;
  assign w_store_full = r_valid;
`endif

  // Frame sequencer: the word is captured on entry to LOAD so a refill of the
  // storage during LOAD cannot disturb the frame in flight
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_phase     <= 9'd0;
      r_bit       <= 4'd0;
      r_shreg     <= 16'd0;
      r_dac_clk   <= 1'b0;
      r_cs_n      <= 1'b1;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_LOAD;
            r_shreg <= {CTRL, w_head};
            r_cs_n  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_state   <= S_SHIFT;
          r_phase   <= 9'd0;
          r_bit     <= 4'd0;
          r_dac_clk <= 1'b0;
        end
        S_SHIFT: begin
          if (r_phase == LP_LAST) begin
            r_phase   <= 9'd0;
            r_dac_clk <= 1'b0;
            if (r_bit == 4'd15) begin
              r_state <= S_END;
              r_cs_n  <= 1'b1;
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_shreg <= {r_shreg[14:0], 1'b0};
            end
          end else begin
            r_phase   <= r_phase + 9'd1;
            r_dac_clk <= ((r_phase + 9'd1) >= LP_HALF);
          end
        end
        S_END: begin
          if (r_phase == LP_LAST) begin
            r_phase <= 9'd0;
            if (!w_empty) begin
              r_state <= S_LOAD;
              r_shreg <= {CTRL, w_head};
              r_cs_n  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_phase     <= r_phase + 9'd1;
            r_word_done <= ((r_phase + 9'd1) == LP_LAST);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dac_clk   = r_dac_clk;
  assign dac_cs_n  = r_cs_n;
  assign dac_din   = r_shreg[15];
  assign busy      = (r_state != S_IDLE);
  assign word_done = r_word_done;

endmodule

// File: tb/tb_dac_com.sv
// Bench for dac_com: a frame-timeline model (offset within the current frame
// plus a sample queue) predicts every output each cycle; literal checks pin
// the model on the documented scenarios. Build with DAC_FIFO_EN for FIFO mode.
module tb_dac_com;

  localparam int         D  = 2;
  localparam logic [3:0] CT = 4'b0011;
`ifdef DAC_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        osc_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en   = 1'b0;
  logic [11:0] wr_data = 12'd0;
  logic        full, dac_clk, dac_cs_n, dac_din, busy, word_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wd_count = 0;
  int last_wd_cyc  = 0;
  int last_acc_cyc = 0;

  // Model state: -1 when idle, otherwise cycle offset inside the frame (0 = LOAD)
  int          frame_off = -1;
  logic [15:0] m_word    = 16'd0;
  logic [11:0] mq[$];

  // Frames reconstructed from the serial pins
  logic [15:0] rx_words[$];
  int          rx_lens[$];
  int          mon_len  = 0;
  logic [15:0] mon_sh   = 16'd0;
  logic        mon_prev = 1'b0;

  dac_com #(.CLK_DIV(D), .CTRL(CT)) dut (
    .osc_clk  (osc_clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .dac_clk  (dac_clk),
    .dac_cs_n (dac_cs_n),
    .dac_din  (dac_din),
    .busy     (busy),
    .word_done(word_done)
  );

  initial forever #5 osc_clk = ~osc_clk;

  always @(posedge osc_clk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the frame-timeline model
  always @(negedge osc_clk) begin
    logic e_cs, e_clk, e_din, e_busy, e_wd, e_full, acc;
    int   k, nxt;
    if (!reset_n) begin
      mq.delete();
      frame_off = -1;
      chk1("rst_cs_n", dac_cs_n, 1'b1);
      chk1("rst_dac_clk", dac_clk, 1'b0);
      chk1("rst_din", dac_din, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_word_done", word_done, 1'b0);
      chk1("rst_full", full, 1'b0);
    end else begin
      e_cs = 1'b1; e_clk = 1'b0; e_din = 1'b0; e_busy = 1'b0; e_wd = 1'b0;
      if (frame_off >= 0) begin
        e_busy = 1'b1;
        if (frame_off == 0) begin
          e_cs  = 1'b0;
          e_din = m_word[15];
        end else if (frame_off <= 32 * D) begin
          k     = frame_off - 1;
          e_cs  = 1'b0;
          e_clk = (k % (2 * D)) >= D;
          e_din = m_word[15 - k / (2 * D)];
        end else begin
          e_wd = (frame_off == 34 * D);
        end
      end
      e_full = (mq.size() == DEPTH) && (frame_off != 0);
      chk1("cs_n", dac_cs_n, e_cs);
      chk1("dac_clk", dac_clk, e_clk);
      chk1("busy", busy, e_busy);
      chk1("word_done", word_done, e_wd);
      chk1("full", full, e_full);
      if (!e_cs) chk1("din", dac_din, e_din);
      if (word_done) begin
        wd_count++;
        last_wd_cyc = cyc;
      end
      // Advance the model across the coming rising edge
      acc = wr_en && !e_full;
      if (frame_off < 0 || frame_off == 34 * D) nxt = (mq.size() > 0) ? 0 : -1;
      else                                      nxt = frame_off + 1;
      if (frame_off == 0) void'(mq.pop_front());
      if (nxt == 0) m_word = {CT, mq[0]};
      if (acc) begin
        mq.push_back(wr_data);
        last_acc_cyc = cyc + 1;
      end
      frame_off = nxt;
    end
  end

  // Serial monitor: shift dac_din on each dac_clk rise while cs_n is low
  always @(negedge osc_clk) begin
    if (!reset_n) begin
      mon_len = 0;
      mon_sh  = 16'd0;
    end else if (!dac_cs_n) begin
      mon_len++;
      if (dac_clk && !mon_prev) mon_sh = {mon_sh[14:0], dac_din};
    end else if (mon_len > 0) begin
      rx_words.push_back(mon_sh);
      rx_lens.push_back(mon_len);
      mon_len = 0;
    end
    mon_prev = dac_clk;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge osc_clk);
      #1;
    end
  endtask

  task automatic push(input logic [11:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge osc_clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_words.size() < n && k < 3000) begin
      @(posedge osc_clk);
      #1;
      k++;
    end
    chk32("rx_wait", (rx_words.size() >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int base, acc_a, wd_before, rx_before, k;
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(6);

    // Single sample: frame contents, select width, word_done latency
    base = rx_words.size();
    push(12'hA5C);
    acc_a = last_acc_cyc;
    wait_rx(base + 1);
    idle(10);
    if (rx_words.size() > base) begin
      chk32("a5c_word", int'(rx_words[base]), 32'h3A5C);
      chk32("a5c_cs_len", rx_lens[base], 65);
    end
    chk32("a5c_wd_latency", last_wd_cyc - acc_a, 69);
    idle(5);

    // Consecutive pushes 000 / FFF
    push(12'h000);
    push(12'hFFF);
    idle(200);

    // Two pushes one cycle apart: the second lands in the LOAD cycle
    base = rx_words.size();
    push(12'h123);
    idle(1);
    push(12'h456);
    wait_rx(base + 2);
    idle(10);
    if (rx_words.size() > base + 1) begin
      chk32("frame1_123", int'(rx_words[base]), 32'h3123);
      chk32("frame2_456", int'(rx_words[base + 1]), 32'h3456);
    end

    // Burst of five back-to-back pushes
    for (int i = 1; i <= 5; i++) push(12'(i));
    idle(400);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 99) < 20);
      wr_data = 12'($urandom);
      @(posedge osc_clk);
      #1;
    end
    wr_en = 1'b0;
    idle(400);

    // Reset in the middle of bit 7 with a sample buffered behind the frame
    push(12'h7E1);
    k = 0;
    while (dac_cs_n && k < 50) begin
      idle(1);
      k++;
    end
    chk1("abort_frame_started", dac_cs_n, 1'b0);
    push(12'h222);
    idle(29);
    wd_before = wd_count;
    rx_before = rx_words.size();
    reset_n = 1'b0;
    #1;
    chk1("abort_cs_n", dac_cs_n, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_dac_clk", dac_clk, 1'b0);
    chk1("abort_full", full, 1'b0);
    chk1("abort_word_done", word_done, 1'b0);
    idle(3);
    reset_n = 1'b1;

    // Long quiet period: nothing may come out
    idle(100);
    chk32("abort_no_pulse", wd_count, wd_before);
    chk32("abort_no_frame", rx_words.size(), rx_before);
    chk1("quiet_busy", busy, 1'b0);
    chk1("quiet_dac_clk", dac_clk, 1'b0);
    chk1("quiet_cs_n", dac_cs_n, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
